mux4x1_8bits: RTL and testbench

Transmit-side 4-lane-to-1 byte serializer for the PCIe PHY TX path; the inverse of the receive-side 1x4 byte demux. It accepts one 4-lane word (four bytes plus per-lane valid bits) through a ready/valid handshake and emits its lanes in order 0,1,2,3 as a byte stream, one byte per handshake cycle. A two-entry buffer (active + shadow) sustains one word per four output cycles with no bubbles.

---
 rtl/mux4x1_8bits_if.sv | 33 +++
 rtl/mux4x1_8bits.sv | 116 +++++++++++
 tb/tb_mux4x1_8bits.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4x1_8bits_if.sv
// Word-in / byte-out handshake bundle for the 4-lane TX serializer.
// master drives words and readyOut; slave is the serializer.
interface mux4x1_8bits_if #(
  parameter int DATA_W = 8
);
  logic              validIn;
  logic [3:0]        validLanesIn;
  logic [DATA_W-1:0] In0;
  logic [DATA_W-1:0] In1;
  logic [DATA_W-1:0] In2;
  logic [DATA_W-1:0] In3;
  logic              readyIn;
  logic              validOut;
  logic              readyOut;
  logic [DATA_W-1:0] dataOut;
  logic [1:0]        laneOut;

  modport master (
    output validIn, validLanesIn,
    output In0, In1, In2, In3,
    output readyOut,
    input  readyIn, validOut,
    input  dataOut, laneOut
  );

  modport slave (
    input  validIn, validLanesIn,
    input  In0, In1, In2, In3,
    input  readyOut,
    output readyIn, validOut,
    output dataOut, laneOut
  );
endinterface

// File: rtl/mux4x1_8bits.sv
// PCIe TX 4-lane to 1 byte serializer, active + shadow word buffer.
// Define MUX4X1_SKIP_INVALID_EN to make invalid lanes cost zero cycles.
module mux4x1_8bits #(
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           reset,
  mux4x1_8bits_if.slave bus
);
  typedef logic [3:0][DATA_W-1:0] word_t;

  word_t      act_d;
  word_t      shd_d;
  word_t      in_d;
  logic [3:0] act_v;
  logic [3:0] shd_v;
  logic       act_full;
  logic       shd_full;
  logic [1:0] ptr;
  logic [1:0] nxt;
  logic [1:0] first_in;
  logic [1:0] first_shd;
  logic       last;
  logic       step;
  logic       drain;
  logic       acc;
  logic       keep;
  logic       load_act;
  logic       cur_v;

  assign in_d = {bus.In3, bus.In2, bus.In1, bus.In0};
  assign cur_v = act_v[ptr];

  assign bus.readyIn  = !shd_full;
  assign bus.validOut = act_full && cur_v;
  assign bus.dataOut  = bus.validOut ? act_d[ptr] : '0;
  assign bus.laneOut  = ptr;

  // an invalid lane never waits on the sink
  assign step = act_full && (!cur_v || bus.readyOut);
  assign drain = step && last;
  assign acc = bus.validIn && bus.readyIn;
  assign load_act = !act_full || (drain && !shd_full);

`ifdef MUX4X1_SKIP_INVALID_EN
  function automatic logic [1:0] lowest(
    input logic [3:0] m
  );
    logic [1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [2:0] seek(
    input logic [3:0] m,
    input logic [2:0] lo
  );
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (3'(i) >= lo && m[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction

  logic [2:0] ahead;

  assign ahead = seek(act_v, {1'b0, ptr} + 3'd1);
  assign nxt = ahead[1:0];
  assign last = !ahead[2];
  assign keep = |bus.validLanesIn;
  assign first_in = lowest(bus.validLanesIn);
  assign first_shd = lowest(shd_v);
`else
  assign nxt = ptr + 2'd1;
  assign last = &ptr;
  assign keep = 1'b1;
  assign first_in = 2'd0;
  assign first_shd = 2'd0;
`endif

  // buffer fill/drain and lane pointer walk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_d    <= '0;
      act_v    <= '0;
      act_full <= 1'b0;
      shd_d    <= '0;
      shd_v    <= '0;
      shd_full <= 1'b0;
      ptr      <= '0;
    end else begin
      if (step) ptr <= nxt;
      if (drain) begin
        act_full <= shd_full;
        act_d    <= shd_d;
        act_v    <= shd_v;
        ptr      <= shd_full ? first_shd : 2'd0;
        shd_full <= 1'b0;
      end
      if (acc && keep) begin
        if (load_act) begin
          act_d    <= in_d;
          act_v    <= bus.validLanesIn;
          act_full <= 1'b1;
          ptr      <= first_in;
        end else begin
          shd_d    <= in_d;
          shd_v    <= bus.validLanesIn;
          shd_full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux4x1_8bits.sv
// Scoreboard bench for the 4-lane TX serializer.
// Expected bytes queue on acceptance; a monitor checks each handshake.
module tb_mux4x1_8bits;
  logic clk = 1'b0;
  logic reset;

  mux4x1_8bits_if bus ();

  mux4x1_8bits dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  logic [9:0] sb[$];

`ifdef MUX4X1_SKIP_INVALID_EN
  logic [8:0] exp_lm [4] = '{9'h122, 9'h144, 9'h000, 9'h000};
  int exp_inv = 1;
`else
  logic [8:0] exp_lm [4] = '{9'h000, 9'h122, 9'h000, 9'h144};
  int exp_inv = 4;
`endif

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // pop and compare on every output handshake
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset && bus.validOut && bus.readyOut) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected byte: got lane %0d data %0h want none",
                 bus.laneOut, bus.dataOut);
      end else begin
        e = sb.pop_front();
        chk("sb lane/data", {22'd0, bus.laneOut, bus.dataOut}, {22'd0, e});
      end
    end
  end

  task automatic send(
    input logic [31:0] w,
    input logic [3:0]  m
  );
    logic r;
    int   n;
    bus.validIn = 1'b1;
    bus.validLanesIn = m;
    bus.In0 = w[7:0];
    bus.In1 = w[15:8];
    bus.In2 = w[23:16];
    bus.In3 = w[31:24];
    r = 1'b0;
    n = 0;
    while (!r && n < 200) begin
      @(negedge clk);
      r = bus.readyIn;
      @(posedge clk);
      n++;
    end
    #1 bus.validIn = 1'b0;
    if (!r) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send timeout: got readyIn 0 want 1 for word %0h", w);
    end else begin
      for (int i = 0; i < 4; i++)
        if (m[i]) sb.push_back({2'(i), w[8*i +: 8]});
    end
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_lane2();
    int n;
    n = 0;
    while (!(bus.validOut && bus.laneOut == 2'd2) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " readyIn"}, 32'(bus.readyIn), 32'd1);
    chk({tag, " validOut"}, 32'(bus.validOut), 32'd0);
    chk({tag, " dataOut"}, 32'(bus.dataOut), 32'd0);
    chk({tag, " laneOut"}, 32'(bus.laneOut), 32'd0);
  endtask

  initial begin
    int     n;
    int     h0;
    longint t0;

    reset = 1'b0;
    bus.validIn = 1'b0;
    bus.validLanesIn = 4'h0;
    bus.In0 = '0;
    bus.In1 = '0;
    bus.In2 = '0;
    bus.In3 = '0;
    bus.readyOut = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b1;

    // streaming, three words back to back
    fork
      begin
        send(32'hCCEEDDFF, 4'hF);
        send(32'h88AA99BB, 4'hF);
        send(32'hDDFF7788, 4'hF);
      end
      begin
        int  sn;
        int  gaps;
        logic lo;
        sn = 0;
        gaps = 0;
        lo = 1'b0;
        while (!bus.validOut && sn < 50) begin
          @(posedge clk);
          #1;
          sn++;
        end
        for (int i = 0; i < 12; i++) begin
          if (!bus.validOut) gaps++;
          if (!bus.readyIn) lo = 1'b1;
          @(posedge clk);
          #1;
        end
        chk("stream gaps", 32'(gaps), 32'd0);
        chk("stream readyIn low", 32'(lo), 32'd1);
      end
    join
    drain_all();

    // backpressure on lane 2
    send(32'hCCEEDDFF, 4'hF);
    wait_lane2();
    bus.readyOut = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp data", 32'(bus.dataOut), 32'hEE);
      chk("bp lane", 32'(bus.laneOut), 32'd2);
    end
    bus.readyOut = 1'b1;
    @(posedge clk);
    #1;
    chk("bp next data", 32'(bus.dataOut), 32'hCC);
    chk("bp next lane", 32'(bus.laneOut), 32'd3);
    drain_all();

    // both buffers full under backpressure
    bus.readyOut = 1'b0;
    fork
      begin
        send(32'h04030201, 4'hF);
        send(32'h08070605, 4'hF);
        send(32'h0C0B0A09, 4'hF);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("full readyIn", 32'(bus.readyIn), 32'd0);
        chk("full hold data", 32'(bus.dataOut), 32'h01);
        bus.readyOut = 1'b1;
      end
    join
    drain_all();

    // lane mask 1010
    send(32'h44332211, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mask cyc%0d", i),
          {23'd0, bus.validOut, bus.dataOut}, {23'd0, exp_lm[i]});
      @(posedge clk);
      #1;
    end
    drain_all();

    // all-invalid word then a full word
    send(32'h00000000, 4'b0000);
    t0 = $time;
    send(32'h88776655, 4'hF);
    n = 0;
    while (!bus.validOut && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("inv idle cycles", 32'(($time - t0) / 10), 32'(exp_inv));
    chk("inv first data", 32'(bus.dataOut), 32'h55);
    drain_all();
    chk("sb empty", 32'(sb.size()), 32'd0);

    // reset mid-word after lane 1
    send(32'hCCEEDDFF, 4'hF);
    wait_lane2();
    reset = 1'b0;
    #1;
    chk_reset_vals("mid rst");
    sb.delete();
    h0 = hs_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post rst bytes", 32'(hs_cnt - h0), 32'd0);
    chk("post rst validOut", 32'(bus.validOut), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
